imem_loader: RTL and testbench

- Boot-time writer for the single-cycle MIPS instruction memory.
- Receives a byte stream: 16-bit word count, then big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses from 0.
- Holds the CPU in reset until the whole image is loaded; the CPU then fetches the image from PC 0.

---
 rtl/imem_loader_if.sv | 43 ++++
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake, the instruction-memory write port and
// the boot status of the instruction-memory loader.
//
// Signals:
//   start        one-cycle pulse that begins a load              (master -> slave)
//   rx_valid     byte available on rx_data                       (master -> slave)
//   rx_data[7:0] stream byte                                     (master -> slave)
//   rx_ready     loader accepts a byte this cycle                (slave -> master)
//   im_we        instruction-memory write strobe                 (slave -> master)
//   im_addr      word address of the write (ADDR_W bits)         (slave -> master)
//   im_wdata     instruction word                                (slave -> master)
//   cpu_reset    active-high reset to the MIPS core              (slave -> master)
//   done         image loaded, CPU released                      (slave -> master)
//   err          load rejected, CPU held                         (slave -> master)
//   words_loaded words written in the current or last load       (slave -> master)
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;
  logic [15:0]       words_loaded;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, im_we, im_addr, im_wdata, cpu_reset, done, err, words_loaded
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, im_we, im_addr, im_wdata, cpu_reset, done, err, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the single-cycle MIPS instruction memory. Accepts a
// byte stream (16-bit big-endian word count, then big-endian 32-bit words),
// writes the words to consecutive word addresses from 0 and holds the CPU in
// reset until the whole image is in memory.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-low reset
//   bus    imem_loader_if.slave: start, rx_valid/rx_data/rx_ready,
//          im_we/im_addr/im_wdata, cpu_reset, done, err, words_loaded
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a trailing byte equal to the XOR of all data bytes must
//   follow the image; a mismatch rejects the load (words stay in memory).
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  logic              r_rdy;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_words;
  logic [15:0]       r_count;
  logic [23:0]       r_acc;
  logic [1:0]        r_bidx;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic        w_xfer;
  logic [15:0] w_hdr;
  logic [31:0] w_word;
  logic        w_last;

  assign w_xfer = bus.rx_valid & r_rdy;
  assign w_hdr  = {r_count[15:8], bus.rx_data};
  assign w_word = {r_acc, bus.rx_data};
  // True during the strobe of the final word (words_loaded not yet bumped).
  assign w_last = ((r_words + 16'd1) == r_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rdy     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_words   <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_bidx    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor     <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_state   <= S_HDR_HI;
            r_rdy     <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_words   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor     <= '0;
`endif
          end
        end
        S_HDR_HI: begin
          if (w_xfer) begin
            r_count[15:8] <= bus.rx_data;
            r_state       <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= bus.rx_data;
            r_bidx       <= 2'd0;
            if (w_hdr > DEPTH_W) begin
              r_state <= S_ERR;
              r_rdy   <= 1'b0;
              r_err   <= 1'b1;
            end else if (w_hdr == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state   <= S_CSUM;
`else
              r_state   <= S_DONE;
              r_rdy     <= 1'b0;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Strobe cycle: count the word just written and leave after the last.
          if (r_we) begin
            r_words <= r_words + 16'd1;
            if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              // A byte offered during the final strobe is the checksum itself.
              if (w_xfer) begin
                r_rdy <= 1'b0;
                if (bus.rx_data == r_xor) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_cpu_rst <= 1'b0;
                end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                end
              end else begin
                r_state <= S_CSUM;
              end
`else
              r_state   <= S_DONE;
              r_rdy     <= 1'b0;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
`endif
            end
          end
          // Byte packing, MSB first; the 4th byte launches the write strobe.
          if (w_xfer && !(r_we && w_last)) begin
            r_acc  <= w_word[23:0];
            r_bidx <= r_bidx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor  <= r_xor ^ bus.rx_data;
`endif
            if (r_bidx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_words[ADDR_W-1:0];
              r_wdata <= w_word;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            r_rdy <= 1'b0;
            if (bus.rx_data == r_xor) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready     = r_rdy;
  assign bus.im_we        = r_we;
  assign bus.im_addr      = r_addr;
  assign bus.im_wdata     = r_wdata;
  assign bus.cpu_reset    = r_cpu_rst;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. A stream-level model watches accepted bytes,
// parses the header and data words and predicts, for every cycle, whether a
// write strobe must be present and with which address and word. Literal
// expectations pin the memory image and the boot status after each load.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory fed by the write port.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.im_we) mem[bus.im_addr] <= bus.im_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- stream-level model ----------------
  logic        m_check;
  int          m_idx;
  int          m_cnt;
  logic [15:0] m_count;
  logic [31:0] m_word;
  logic        m_due;
  int          m_exp_addr;
  logic [31:0] m_exp_data;
  int          m_wr_cnt;

  initial begin
    m_idx = 0; m_cnt = 0; m_count = '0; m_word = '0; m_due = 1'b0;
    m_exp_addr = 0; m_exp_data = '0; m_wr_cnt = 0;
  end

  always @(posedge clk) begin
    m_due = 1'b0;
    if (!reset) begin
      m_idx = 0;
      m_cnt = 0;
      m_wr_cnt = 0;
    end else begin
      if (bus.start) begin
        m_idx = 0;
        m_wr_cnt = 0;
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (m_idx == 0) begin
          m_count[15:8] = bus.rx_data;
        end else if (m_idx == 1) begin
          m_count[7:0] = bus.rx_data;
          m_cnt = int'(m_count);
        end else if (m_idx - 2 < 4 * m_cnt) begin
          m_word = {m_word[23:0], bus.rx_data};
          if ((m_idx - 2) % 4 == 3) begin
            m_due      = 1'b1;
            m_exp_addr = (m_idx - 2) / 4;
            m_exp_data = m_word;
            m_wr_cnt++;
          end
        end
        m_idx++;
      end
    end
  end

  // Every cycle: a strobe exactly when the model expects one, with its payload.
  always @(negedge clk) begin
    if (m_check) begin
      chk("im_we", {31'd0, bus.im_we}, {31'd0, m_due});
      if (m_due) begin
        chk("im_addr", {24'd0, bus.im_addr}, m_exp_addr);
        chk("im_wdata", bus.im_wdata, m_exp_data);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) begin
      failures++;
      checks++;
      $display("FAIL rx_ready_timeout act=0 exp=1 byte=%h", b);
    end
    @(posedge clk);
  endtask

  task automatic drive_gappy(input logic [7:0] b);
    drive_byte(b);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("rx_ready_gap", {31'd0, bus.rx_ready}, 32'd1);
  endtask

  task automatic idle_rx();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("start_words", {16'd0, bus.words_loaded}, 32'd0);
    chk("start_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    chk("start_err", {31'd0, bus.err}, 32'd0);
    chk("start_done", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic expect_status(input string tag, input logic d, input logic e,
                               input logic cr, input logic [15:0] w);
    chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, d});
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, e});
    chk({tag, "_cpu_reset"}, {31'd0, bus.cpu_reset}, {31'd0, cr});
    chk({tag, "_words"}, {16'd0, bus.words_loaded}, {16'd0, w});
  endtask

  task automatic expect_reset_values(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    chk({tag, "_im_we"}, {31'd0, bus.im_we}, 32'd0);
    chk({tag, "_im_addr"}, {24'd0, bus.im_addr}, 32'd0);
    chk({tag, "_im_wdata"}, bus.im_wdata, 32'd0);
    expect_status(tag, 1'b0, 1'b0, 1'b1, 16'd0);
  endtask

  initial begin
    checks = 0; failures = 0; m_check = 1'b0;
    reset = 1'b0;
    bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    expect_reset_values("rst");
    reset = 1'b1;
    m_check = 1'b1;

    // Two-word image.
    pulse_start();
    drive_byte(8'h00); drive_byte(8'h02);
    drive_byte(8'h3C); drive_byte(8'h08); drive_byte(8'h00); drive_byte(8'h05);
    drive_byte(8'h21); drive_byte(8'h09); drive_byte(8'h00); drive_byte(8'h01);
    idle_rx();
    expect_status("t1_strobe", 1'b0, 1'b0, 1'b1, 16'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    drive_byte(8'h18);
    idle_rx();
`else
    @(negedge clk);
`endif
    expect_status("t1_end", 1'b1, 1'b0, 1'b0, 16'd2);
    chk("t1_words_model", {16'd0, bus.words_loaded}, m_wr_cnt);
    chk("t1_mem0", mem[0], 32'h3C080005);
    chk("t1_mem1", mem[1], 32'h21090001);

    // Oversized count is rejected right after the header.
    pulse_start();
    drive_byte(8'h01); drive_byte(8'h01);
    idle_rx();
    expect_status("t2_err", 1'b0, 1'b1, 1'b1, 16'd0);
    chk("t2_rx_ready", {31'd0, bus.rx_ready}, 32'd0);

    // Restart from ERR with a throttled one-word stream.
    pulse_start();
    drive_gappy(8'h00); drive_gappy(8'h01);
    drive_gappy(8'hDE); drive_gappy(8'hAD); drive_gappy(8'hBE); drive_gappy(8'hEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    drive_byte(8'h22);
    idle_rx();
`else
    @(negedge clk);
`endif
    expect_status("t3_end", 1'b1, 1'b0, 1'b0, 16'd1);
    chk("t3_mem0", mem[0], 32'hDEADBEEF);

    // Reset in the middle of a word, then a fresh image.
    pulse_start();
    drive_byte(8'h00); drive_byte(8'h01); drive_byte(8'h11); drive_byte(8'h22);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #2 reset = 1'b0;
    #1 expect_reset_values("t4_async");
    repeat (2) @(negedge clk);
    expect_reset_values("t4_held");
    reset = 1'b1;
    pulse_start();
    drive_byte(8'h00); drive_byte(8'h01);
    drive_byte(8'hCA); drive_byte(8'hFE); drive_byte(8'hBA); drive_byte(8'hBE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    idle_rx();
    drive_byte(8'h30);
`endif
    idle_rx();
`ifndef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
`endif
    expect_status("t4_end", 1'b1, 1'b0, 1'b0, 16'd1);
    chk("t4_mem0", mem[0], 32'hCAFEBABE);

    // Zero-word image.
    pulse_start();
    drive_byte(8'h00); drive_byte(8'h00);
    idle_rx();
`ifdef IMEM_LOADER_CHECKSUM_EN
    expect_status("t5_csum_wait", 1'b0, 1'b0, 1'b1, 16'd0);
    drive_byte(8'h00);
    idle_rx();
    expect_status("t5_ok", 1'b1, 1'b0, 1'b0, 16'd0);
    pulse_start();
    drive_byte(8'h00); drive_byte(8'h00); drive_byte(8'h01);
    idle_rx();
    expect_status("t5_bad", 1'b0, 1'b1, 1'b1, 16'd0);

    // Checksum good then bad on the same one-word image.
    pulse_start();
    drive_byte(8'h00); drive_byte(8'h01);
    drive_byte(8'h12); drive_byte(8'h34); drive_byte(8'h56); drive_byte(8'h78);
    idle_rx();
    drive_byte(8'h08);
    idle_rx();
    expect_status("t6_ok", 1'b1, 1'b0, 1'b0, 16'd1);
    pulse_start();
    drive_byte(8'h00); drive_byte(8'h01);
    drive_byte(8'h12); drive_byte(8'h34); drive_byte(8'h56); drive_byte(8'h78);
    idle_rx();
    drive_byte(8'h09);
    idle_rx();
    expect_status("t6_bad", 1'b0, 1'b1, 1'b1, 16'd1);
    chk("t6_mem0", mem[0], 32'h12345678);
`else
    expect_status("t5_done", 1'b1, 1'b0, 1'b0, 16'd0);
    chk("t5_mem0_kept", mem[0], 32'hCAFEBABE);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
